// File: rtl/aes_pkg.sv
// Shared AES datapath widths, bank state encoding and row/column byte helpers.
// Column word layout: [31:24]=row0 .. [7:0]=row3; a state is four columns, column 0 first.
package aes_pkg;

  localparam int COL_W    = 32;
  localparam int BYTE_W   = 8;
  localparam int NUM_COLS = 4;

  typedef logic [NUM_COLS-1:0][COL_W-1:0] state_t;

  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_state_e;

  function automatic logic [BYTE_W-1:0] get_byte(input state_t st, input logic [1:0] row,
                                                 input logic [1:0] col);
    return st[col][COL_W-1-BYTE_W*row -: BYTE_W];
  endfunction

  // Row r of output column c comes from column c-r (inverse) or c+r (forward), mod 4.
  function automatic logic [COL_W-1:0] shift_col(input state_t st, input logic [1:0] col,
                                                 input logic fwd);
    logic [COL_W-1:0] res;
    logic [1:0]       src;
    res = '0;
    for (int r = 0; r < NUM_COLS; r++) begin
      src = fwd ? col + 2'(r) : col - 2'(r);
      res[COL_W-1-BYTE_W*r -: BYTE_W] = get_byte(st, 2'(r), src);
    end
    return res;
  endfunction

endpackage

// File: rtl/isr_bank.sv
// One 128-bit state buffer with its EMPTY/FILLING/FULL/DRAINING FSM and a combinational permuted read port.
// Latency: FULL the cycle after column 3 is written; backpressure: contents frozen while FULL/DRAINING. Macro ISR_FWD_MODE_EN adds a per-bank mode bit.
module isr_bank
  import aes_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        wr_en,
  input  logic [1:0]  wr_idx,
  input  logic [31:0] wr_col,
`ifdef ISR_FWD_MODE_EN
  input  logic        wr_mode,
`endif
  input  logic        rd_sel,
  input  logic        rd_done,
  input  logic [1:0]  rd_idx,
  output logic [1:0]  state,
  output logic [31:0] rd_col
);

  bank_state_e state_q, state_d;
  state_t      mem;
  logic        fwd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     state_q <= BANK_EMPTY;
    else if (flush) state_q <= BANK_EMPTY;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BANK_EMPTY:    if (wr_en) state_d = BANK_FILLING;
      BANK_FILLING:  if (wr_en && wr_idx == 2'd3) state_d = BANK_FULL;
      BANK_FULL:     if (rd_sel) state_d = BANK_DRAINING;
      BANK_DRAINING: if (rd_done) state_d = BANK_EMPTY;
      default:       state_d = BANK_EMPTY;
    endcase
  end

  // Payload is only trusted while FULL/DRAINING, so it carries no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_col;
  end

`ifdef ISR_FWD_MODE_EN
  logic mode_q;
  always_ff @(posedge clk) begin
    if (wr_en && wr_idx == 2'd0) mode_q <= wr_mode;
  end
  assign fwd = mode_q;
`else
  assign fwd = 1'b0;
`endif

  assign state  = state_q;
  assign rd_col = shift_col(mem, rd_idx, fwd);

endmodule

// File: rtl/inv_shift_row_stream.sv
// Streaming AES InvShiftRows over 4-beat column blocks, ping-pong banked; ISR_FWD_MODE_EN adds mode_fwd.
// Latency: out_valid the cycle after input column 3; backpressure: output held stable, in_ready low once the write bank is full.
module inv_shift_row_stream
  import aes_pkg::*;
#(
  parameter int NUM_BANKS = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_col,
`ifdef ISR_FWD_MODE_EN
  input  logic        mode_fwd,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_col,
  output logic        out_last
);

  logic [1:0]           wc, rc;
  logic                 wptr, rptr;
  logic                 in_fire, out_fire;
  logic [NUM_BANKS-1:0] wsel, rsel, wr_open, rd_avail;
  logic [1:0]           bank_st  [NUM_BANKS];
  logic [31:0]          bank_col [NUM_BANKS];

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    assign wsel[b]     = (wptr == 1'(b));
    assign rsel[b]     = (rptr == 1'(b));
    assign wr_open[b]  = (bank_st[b] == BANK_EMPTY) || (bank_st[b] == BANK_FILLING);
    assign rd_avail[b] = (bank_st[b] == BANK_FULL) || (bank_st[b] == BANK_DRAINING);

    isr_bank u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (flush),
      .wr_en   (in_fire && wsel[b]),
      .wr_idx  (wc),
      .wr_col  (in_col),
`ifdef ISR_FWD_MODE_EN
      .wr_mode (mode_fwd),
`endif
      .rd_sel  (rsel[b]),
      .rd_done (out_fire && rsel[b] && rc == 2'd3),
      .rd_idx  (rc),
      .state   (bank_st[b]),
      .rd_col  (bank_col[b])
    );
  end

  assign in_ready  = |(wsel & wr_open);
  assign out_valid = |(rsel & rd_avail);
  assign out_last  = out_valid && (rc == 2'd3);
  assign in_fire   = in_valid && in_ready && !flush;
  assign out_fire  = out_valid && out_ready && !flush;

  always_comb begin
    out_col = '0;
    for (int b = 0; b < NUM_BANKS; b++)
      if (rsel[b] && rd_avail[b]) out_col = bank_col[b];
  end

  // Banks fill and drain strictly in order, so the read pointer always names the oldest block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wc   <= 2'd0;
      rc   <= 2'd0;
      wptr <= 1'b0;
      rptr <= 1'b0;
    end else if (flush) begin
      wc   <= 2'd0;
      rc   <= 2'd0;
      wptr <= 1'b0;
      rptr <= 1'b0;
    end else begin
      if (in_fire) begin
        wc <= wc + 2'd1;
        if (wc == 2'd3 && NUM_BANKS == 2) wptr <= ~wptr;
      end
      if (out_fire) begin
        rc <= rc + 2'd1;
        if (rc == 2'd3 && NUM_BANKS == 2) rptr <= ~rptr;
      end
    end
  end

endmodule

// File: tb/tb_inv_shift_row_stream.sv
// Scoreboard bench for inv_shift_row_stream: byte-matrix reference model, randomized blocks, stall/reset/flush cases.
// A second instance with NUM_BANKS=1 covers the no-overlap handshake.
`timescale 1ns/1ps
module tb_inv_shift_row_stream;

  typedef logic [31:0] blk_t [4];
  typedef struct { logic [31:0] col; logic last; } exp_t;

`ifdef ISR_FWD_MODE_EN
  localparam bit FWD_EN = 1'b1;
  logic mode_fwd = 1'b0;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, out_last;
  logic [31:0] in_col = '0, out_col;
  logic        in_valid1 = 1'b0, in_ready1, out_valid1, out_ready1 = 1'b0, out_last1;
  logic [31:0] in_col1 = '0, out_col1;

  int   n_vec = 0, n_err = 0, cyc = 0, stall_waits = 0;
  bit   rand_rdy = 1'b0;
  exp_t exp_q[$];
  int   fire_cyc[$];

  always #5 clk = ~clk;

  inv_shift_row_stream #(.NUM_BANKS(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_col(in_col),
`ifdef ISR_FWD_MODE_EN
    .mode_fwd(mode_fwd),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_col(out_col), .out_last(out_last)
  );

  inv_shift_row_stream #(.NUM_BANKS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_col(in_col1),
`ifdef ISR_FWD_MODE_EN
    .mode_fwd(1'b0),
`endif
    .out_valid(out_valid1), .out_ready(out_ready1), .out_col(out_col1), .out_last(out_last1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h, want %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // out[r][c] = in[r][(c-r) mod 4], or (c+r) mod 4 when forward.
  function automatic blk_t ref_model(input blk_t in, input bit fwd);
    blk_t       o;
    logic [7:0] m [4][4];
    int         src;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) m[r][c] = 8'(in[c] >> (24 - 8 * r));
    for (int c = 0; c < 4; c++) begin
      o[c] = '0;
      for (int r = 0; r < 4; r++) begin
        src  = fwd ? (c + r) % 4 : (c - r + 4) % 4;
        o[c] = o[c] | (32'(m[r][src]) << (24 - 8 * r));
      end
    end
    return o;
  endfunction

  task automatic send_col(input logic [31:0] c);
    int waits = 0;
    in_valid = 1'b1;
    in_col   = c;
    @(negedge clk);
    while (!in_ready && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_vec++; n_err++;
      $display("FAIL in_ready_timeout: in_ready=%0b, want 1", in_ready);
    end
    stall_waits += waits;
    @(posedge clk); #1;
  endtask

  task automatic send_block(input blk_t c, input bit fwd, input bit use_exp, input blk_t expv);
    blk_t e;
    if (use_exp) e = expv;
    else         e = ref_model(c, FWD_EN && fwd);
    for (int k = 0; k < 4; k++) begin
`ifdef ISR_FWD_MODE_EN
      mode_fwd = (k == 0) ? fwd : 1'($urandom);
`endif
      send_col(c[k]);
    end
    for (int k = 0; k < 4; k++) exp_q.push_back('{col: e[k], last: (k == 3)});
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL %s_drain: %0d beats outstanding, want 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  function automatic blk_t rand_blk();
    blk_t b;
    for (int k = 0; k < 4; k++) b[k] = $urandom;
    return b;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk); #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  // Output monitor: scoreboard pop, hold-under-stall and zero-gating checks.
  initial begin
    logic        stall_prev;
    logic [31:0] col_prev;
    logic        last_prev;
    exp_t        e;
    stall_prev = 1'b0;
    col_prev   = '0;
    last_prev  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n || flush) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check("hold_valid", out_valid, 1);
          check("hold_col", out_col, col_prev);
          check("hold_last", out_last, last_prev);
        end
        if (!out_valid) check("gated_col", out_col, 0);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_out: got %08h, want no beat", out_col);
          end else begin
            e = exp_q.pop_front();
            check("out_col", out_col, e.col);
            check("out_last", out_last, e.last);
            fire_cyc.push_back(cyc);
          end
        end
        stall_prev = out_valid && !out_ready;
        col_prev   = out_col;
        last_prev  = out_last;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, want finished");
    $fatal(1);
  end

  initial begin
    blk_t d_in, d_exp, f_exp, b;
    int   t0, n;
    d_in  = '{32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F};
    d_exp = '{32'h000D0A07, 32'h04010E0B, 32'h0805020F, 32'h0C090603};
    f_exp = '{32'h00050A0F, 32'h04090E03, 32'h080D0207, 32'h0C01060B};

    // Reset state
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_col", out_col, 0);
    check("rst_out_last", out_last, 0);
    check("rst_nb1_in_ready", in_ready1, 1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Single directed block and first-beat latency
    out_ready = 1'b1;
    send_block(d_in, 1'b0, 1'b1, d_exp);
    in_valid = 1'b0;
    @(negedge clk);
    check("latency_valid", out_valid, 1);
    drain("single");

    // Three back-to-back blocks
    stall_waits = 0;
    fire_cyc.delete();
    for (int i = 0; i < 3; i++) begin
      b = rand_blk();
      send_block(b, 1'b0, 1'b0, b);
    end
    in_valid = 1'b0;
    drain("b2b");
    check("b2b_in_stalls", stall_waits, 0);
    check("b2b_beats", fire_cyc.size(), 12);
    if (fire_cyc.size() >= 12) check("b2b_no_bubble", fire_cyc[11] - fire_cyc[0], 11);

    // Backpressure: both banks full, in_ready must drop
    out_ready = 1'b0;
    b = rand_blk();
    send_block(b, 1'b0, 1'b0, b);
    t0 = cyc;
    b = rand_blk();
    send_block(b, 1'b0, 1'b0, b);
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_in_ready_low", in_ready, 0);
    while (cyc - t0 < 10) @(posedge clk);
    #1;
    check("bp_valid_stalled", out_valid, 1);
    out_ready = 1'b1;
    drain("bp");

    // Async reset mid-block with a full bank pending
    out_ready = 1'b0;
    b = rand_blk();
    send_block(b, 1'b0, 1'b0, b);
    b = rand_blk();
    send_col(b[0]);
    send_col(b[1]);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_out_col", out_col, 0);
    check("arst_out_last", out_last, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    b = rand_blk();
    send_block(b, 1'b0, 1'b0, b);
    in_valid = 1'b0;
    drain("arst");

    // Flush while output column 1 is stalled
    out_ready = 1'b0;
    b = rand_blk();
    send_block(b, 1'b0, 1'b0, b);
    in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("flush_pre_valid", out_valid, 1);
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    flush = 1'b1;
    exp_q.delete();
    @(posedge clk); #1 flush = 1'b0;
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    check("flush_out_col", out_col, 0);
    out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    b = rand_blk();
    send_block(b, 1'b0, 1'b0, b);
    in_valid = 1'b0;
    drain("flush");

    // Random soak with random output backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 12; i++) begin
      n = $urandom_range(0, 3);
      in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
      b = rand_blk();
      send_block(b, 1'($urandom), 1'b0, b);
    end
    in_valid = 1'b0;
    rand_rdy = 1'b0;
    @(posedge clk); #2 out_ready = 1'b1;
    drain("soak");

`ifdef ISR_FWD_MODE_EN
    send_block(d_in, 1'b1, 1'b1, f_exp);
    in_valid = 1'b0;
    drain("fwd");
    send_block(f_exp, 1'b0, 1'b1, d_in);
    in_valid = 1'b0;
    drain("fwd_roundtrip");
`else
    b = f_exp;
    send_block(b, 1'b0, 1'b0, b);
    in_valid = 1'b0;
    drain("inv_of_fwd");
`endif

    // Single-bank instance: no overlap, in_ready returns only after last beat
    out_ready1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid1 = 1'b1;
      in_col1   = d_in[k];
      @(negedge clk);
      check("nb1_fill_ready", in_ready1, 1);
      @(posedge clk); #1;
    end
    in_col1 = 32'hDEADBEEF;
    repeat (3) begin
      @(negedge clk);
      check("nb1_full_ready", in_ready1, 0);
    end
    @(posedge clk); #1 out_ready1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("nb1_valid", out_valid1, 1);
      check("nb1_col", out_col1, d_exp[k]);
      check("nb1_last", out_last1, (k == 3));
      check("nb1_drain_ready", in_ready1, 0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("nb1_freed_ready", in_ready1, 1);
    check("nb1_freed_valid", out_valid1, 0);
    in_valid1 = 1'b0;
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
